// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit carry-lookahead slice is reused
// LSB-first over WIDTH/CHUNK cycles, with the carry registered between chunks.
module chunked_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic [1:0]       o_dbg_state
);

    generate
        if (CHUNK < 1 || WIDTH < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("chunked_adder: WIDTH must be a positive multiple of CHUNK (CHUNK >= 1)");
        end
    endgenerate

    localparam int NCHUNK = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_a_msb;
    logic              r_b_msb;
    logic              r_carry;
    logic [IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_sum;
    logic              r_carry_out;
    logic              r_overflow;
    logic              r_zero;

    logic [WIDTH-1:0]  w_b_eff;
    logic              w_c0;
    logic              w_last;
    logic [CHUNK-1:0]  w_p;
    logic [CHUNK-1:0]  w_g;
    logic [CHUNK:0]    w_c;
    logic [CHUNK-1:0]  w_chunk_sum;
    logic [WIDTH-1:0]  w_chunk_ext;
    logic [WIDTH-1:0]  w_sum_next;

    // Handshakes: a request transfers on a rising edge with in_valid && in_ready;
    // a result transfers on a rising edge with out_valid && out_ready.
    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign o_dbg_state = r_state;

    assign w_b_eff = sub ? ~b : b;
    assign w_c0    = sub ? ~carry_in : carry_in;
    assign w_last  = (r_idx == LAST_IDX);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Carry-lookahead slice; operands are shifted so the active chunk
    // always sits in the low CHUNK bits.
    // ------------------------------------------------------------------
    assign w_p = r_a[CHUNK-1:0] ^ r_b[CHUNK-1:0];
    assign w_g = r_a[CHUNK-1:0] & r_b[CHUNK-1:0];

    always_comb begin : cla
        logic v_c;
        logic v_t;
        v_c    = 1'b0;
        v_t    = 1'b0;
        w_c    = '0;
        w_c[0] = r_carry;
        for (int i = 0; i < CHUNK; i++) begin
            v_c = r_carry;
            for (int k = 0; k <= i; k++) begin
                v_c = v_c & w_p[k];
            end
            for (int j = 0; j <= i; j++) begin
                v_t = w_g[j];
                for (int k = j + 1; k <= i; k++) begin
                    v_t = v_t & w_p[k];
                end
                v_c = v_c | v_t;
            end
            w_c[i+1] = v_c;
        end
    end

    assign w_chunk_sum = w_p ^ w_c[CHUNK-1:0];

    always_comb begin
        w_chunk_ext              = '0;
        w_chunk_ext[CHUNK-1:0]   = w_chunk_sum;
    end

    // Chunk results enter at the top and move down, so after the last chunk
    // chunk 0 lands in bits [CHUNK-1:0].
    assign w_sum_next = (r_sum >> CHUNK) | (w_chunk_ext << (WIDTH - CHUNK));

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a         <= '0;
            r_b         <= '0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a         <= a;
                        r_b         <= w_b_eff;
                        r_a_msb     <= a[WIDTH-1];
                        r_b_msb     <= w_b_eff[WIDTH-1];
                        r_carry     <= w_c0;
                        r_idx       <= '0;
                        r_sum       <= '0;
                        r_carry_out <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_zero      <= 1'b0;
                    end
                end
                S_BUSY: begin
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    r_sum   <= w_sum_next;
                    r_carry <= w_c[CHUNK];
                    if (w_last) begin
                        r_carry_out <= w_c[CHUNK];
                        r_overflow  <= (r_a_msb == r_b_msb) && (w_sum_next[WIDTH-1] != r_a_msb);
                        r_zero      <= (w_sum_next == '0);
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum       = r_sum;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
    assign zero      = r_zero;

endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder: directed cases on an 8/4 instance, randomized
// traffic on 32/4 and 12/3 instances against an arithmetic reference model.
module tb_chunked_adder;

  localparam int N32_OPS = 4500;
  localparam int N12_OPS = 7500;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8;
  logic rst_r;

  int total = 0;
  int bad = 0;

  // ---------------- 8/4 instance ----------------
  logic       v8, s8, ci8, or8;
  logic [7:0] a8, b8;
  logic       ir8, ov8, co8, of8, z8;
  logic [7:0] sum8;
  logic [1:0] st8;

  chunked_adder #(.WIDTH(8), .CHUNK(4)) u_add8 (
    .clk(clk), .reset(rst8), .in_valid(v8), .in_ready(ir8), .a(a8), .b(b8),
    .sub(s8), .carry_in(ci8), .out_valid(ov8), .out_ready(or8), .sum(sum8),
    .carry_out(co8), .overflow(of8), .zero(z8), .o_dbg_state(st8)
  );

  // ---------------- 32/4 instance ----------------
  logic        v32, s32, ci32, or32;
  logic [31:0] a32, b32;
  logic        ir32, ov32, co32, of32, z32;
  logic [31:0] sum32;
  logic [1:0]  st32;

  chunked_adder #(.WIDTH(32), .CHUNK(4)) u_add32 (
    .clk(clk), .reset(rst_r), .in_valid(v32), .in_ready(ir32), .a(a32), .b(b32),
    .sub(s32), .carry_in(ci32), .out_valid(ov32), .out_ready(or32), .sum(sum32),
    .carry_out(co32), .overflow(of32), .zero(z32), .o_dbg_state(st32)
  );

  // ---------------- 12/3 instance ----------------
  logic        v12, s12, ci12, or12;
  logic [11:0] a12, b12;
  logic        ir12, ov12, co12, of12, z12;
  logic [11:0] sum12;
  logic [1:0]  st12;

  chunked_adder #(.WIDTH(12), .CHUNK(3)) u_add12 (
    .clk(clk), .reset(rst_r), .in_valid(v12), .in_ready(ir12), .a(a12), .b(b12),
    .sub(s12), .carry_in(ci12), .out_valid(ov12), .out_ready(or12), .sum(sum12),
    .carry_out(co12), .overflow(of12), .zero(z12), .o_dbg_state(st12)
  );

  // ---------------- checking / model ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result packing: sum in [31:0], carry_out [32], overflow [33], zero [34].
  function automatic logic [63:0] pack(input logic [63:0] s, input logic c, input logic o, input logic z);
    return (s & 64'hFFFF_FFFF) | (64'(c) << 32) | (64'(o) << 33) | (64'(z) << 34);
  endfunction

  function automatic logic [63:0] ref_result(input int w, input logic [63:0] a, input logic [63:0] b,
                                             input logic sub, input logic cin);
    logic [63:0] mask, beff, full, s;
    logic        c0, cout, ovf, a_msb, b_msb, s_msb;
    mask  = (64'd1 << w) - 64'd1;
    beff  = sub ? (~b & mask) : (b & mask);
    c0    = sub ? ~cin : cin;
    full  = (a & mask) + beff + 64'(c0);
    s     = full & mask;
    cout  = full[w];
    a_msb = a[w-1];
    b_msb = beff[w-1];
    s_msb = s[w-1];
    ovf   = (a_msb == b_msb) && (s_msb != a_msb);
    return pack(s, cout, ovf, s == 64'd0);
  endfunction

  function automatic logic [63:0] obs8();
    return pack(64'(sum8), co8, of8, z8);
  endfunction

  function automatic logic [63:0] obs32();
    return pack(64'(sum32), co32, of32, z32);
  endfunction

  function automatic logic [63:0] obs12();
    return pack(64'(sum12), co12, of12, z12);
  endfunction

  // ---------------- 8/4 driver: one full transaction ----------------
  // Entered and left on a negedge with the DUT idle.
  task automatic d8_run(input logic [7:0] a, input logic [7:0] b, input logic s, input logic ci,
                        input int stall, input logic [63:0] e, input string tag);
    int lat;
    check({tag, "_rdy"}, 64'(ir8), 64'd1);
    a8 = a; b8 = b; s8 = s; ci8 = ci; v8 = 1'b1; or8 = 1'b0;
    @(negedge clk);
    check({tag, "_busy_rdy"}, 64'(ir8), 64'd0);
    a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom); ci8 = 1'($urandom);
    or8 = 1'($urandom);
    lat = 0;
    while (!ov8 && lat < 32) begin
      @(negedge clk);
      lat++;
      or8 = 1'($urandom);
    end
    check({tag, "_lat"}, 64'(lat), 64'd2);
    check({tag, "_sum"}, 64'(sum8), e & 64'hFF);
    check({tag, "_cout"}, 64'(co8), 64'(e[32]));
    check({tag, "_ovf"}, 64'(of8), 64'(e[33]));
    check({tag, "_zero"}, 64'(z8), 64'(e[34]));
    or8 = 1'b0;
    repeat (stall) begin
      @(negedge clk);
      check({tag, "_hold"}, obs8(), e);
      check({tag, "_hold_rdy"}, 64'(ir8), 64'd0);
      check({tag, "_hold_vld"}, 64'(ov8), 64'd1);
    end
    or8 = 1'b1; v8 = 1'b0;
    @(negedge clk);
    or8 = 1'b0;
    check({tag, "_rel_vld"}, 64'(ov8), 64'd0);
    check({tag, "_rel_rdy"}, 64'(ir8), 64'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [63:0] exp32_q[$];
  logic [63:0] exp12_q[$];

  initial begin
    int cnt;
    rst8 = 1'b1; rst_r = 1'b1;
    v8 = 0; s8 = 0; ci8 = 0; or8 = 0; a8 = '0; b8 = '0;
    v32 = 0; s32 = 0; ci32 = 0; or32 = 0; a32 = '0; b32 = '0;
    v12 = 0; s12 = 0; ci12 = 0; or12 = 0; a12 = '0; b12 = '0;
    repeat (3) @(negedge clk);
    rst8 = 1'b0;

    check("rst_rdy", 64'(ir8), 64'd1);
    check("rst_vld", 64'(ov8), 64'd0);
    check("rst_outs", obs8(), 64'd0);

    d8_run(8'hFF, 8'h01, 1'b0, 1'b0, 0, pack(64'h00, 1'b1, 1'b0, 1'b1), "add_wrap");
    d8_run(8'h80, 8'h01, 1'b1, 1'b0, 5, pack(64'h7F, 1'b1, 1'b1, 1'b0), "sub_ovf");
    d8_run(8'h0F, 8'h01, 1'b0, 1'b0, 1, pack(64'h10, 1'b0, 1'b0, 1'b0), "chunk_carry");
    d8_run(8'h10, 8'h01, 1'b1, 1'b1, 0, pack(64'h0E, 1'b1, 1'b0, 1'b0), "sub_borrow_in");
    d8_run(8'h00, 8'h01, 1'b1, 1'b0, 0, pack(64'hFF, 1'b0, 1'b0, 1'b0), "sub_neg");
    d8_run(8'h7F, 8'h01, 1'b0, 1'b1, 2, pack(64'h81, 1'b0, 1'b1, 1'b0), "add_ovf");

    for (int n = 0; n < 40; n++) begin
      logic [7:0] ra, rb;
      logic       rs, rc;
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); rc = 1'($urandom);
      d8_run(ra, rb, rs, rc, $urandom_range(0, 2), ref_result(8, 64'(ra), 64'(rb), rs, rc), "rnd8");
    end

    // reset on the first BUSY cycle
    a8 = 8'h12; b8 = 8'h34; s8 = 1'b0; ci8 = 1'b1; v8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0; rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    check("rstbusy_rdy", 64'(ir8), 64'd1);
    check("rstbusy_vld", 64'(ov8), 64'd0);
    check("rstbusy_outs", obs8(), 64'd0);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (ov8) cnt++;
    end
    check("rstbusy_no_vld", 64'(cnt), 64'd0);

    // reset in DONE wins over out_ready
    a8 = 8'h12; b8 = 8'h34; s8 = 1'b0; ci8 = 1'b0; v8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    repeat (2) @(negedge clk);
    check("rstdone_vld_before", 64'(ov8), 64'd1);
    check("rstdone_sum_before", 64'(sum8), 64'h46);
    rst8 = 1'b1; or8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0; or8 = 1'b0;
    check("rstdone_vld", 64'(ov8), 64'd0);
    check("rstdone_rdy", 64'(ir8), 64'd1);
    check("rstdone_outs", obs8(), 64'd0);

    // reset wins over in_valid
    a8 = 8'h05; b8 = 8'h06; v8 = 1'b1; rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0; v8 = 1'b0;
    check("rstprio_rdy", 64'(ir8), 64'd1);
    repeat (3) @(negedge clk);
    check("rstprio_no_vld", 64'(ov8), 64'd0);

    // ---------------- randomized traffic, both widths in parallel ----------------
    rst_r = 1'b0;
    @(negedge clk);
    fork
      begin : rnd32
        for (int n = 0; n < N32_OPS; n++) begin
          logic [63:0] e;
          int lat;
          int stall;
          check("r32_rdy", 64'(ir32), 64'd1);
          a32 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
          b32 = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
          s32 = 1'($urandom); ci32 = 1'($urandom); v32 = 1'b1;
          exp32_q.push_back(ref_result(32, 64'(a32), 64'(b32), s32, ci32));
          @(negedge clk);
          a32 = 32'($urandom); b32 = 32'($urandom); s32 = 1'($urandom); ci32 = 1'($urandom);
          v32 = 1'($urandom); or32 = 1'($urandom);
          lat = 0;
          while (!ov32 && lat < 64) begin
            @(negedge clk);
            lat++;
            or32 = 1'($urandom);
          end
          check("r32_lat", 64'(lat), 64'd8);
          e = exp32_q.pop_front();
          check("r32_result", obs32(), e);
          stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
          or32 = 1'b0;
          repeat (stall) begin
            @(negedge clk);
            check("r32_hold", obs32(), e);
            check("r32_hold_rdy", 64'(ir32), 64'd0);
          end
          or32 = 1'b1; v32 = 1'b0;
          @(negedge clk);
          or32 = 1'b0;
          if (lat >= 64) break;
        end
      end
      begin : rnd12
        for (int n = 0; n < N12_OPS; n++) begin
          logic [63:0] e;
          int lat;
          int stall;
          check("r12_rdy", 64'(ir12), 64'd1);
          a12 = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom);
          b12 = ($urandom_range(0, 7) == 0) ? 12'h800 : 12'($urandom);
          s12 = 1'($urandom); ci12 = 1'($urandom); v12 = 1'b1;
          exp12_q.push_back(ref_result(12, 64'(a12), 64'(b12), s12, ci12));
          @(negedge clk);
          a12 = 12'($urandom); b12 = 12'($urandom); s12 = 1'($urandom); ci12 = 1'($urandom);
          v12 = 1'($urandom); or12 = 1'($urandom);
          lat = 0;
          while (!ov12 && lat < 64) begin
            @(negedge clk);
            lat++;
            or12 = 1'($urandom);
          end
          check("r12_lat", 64'(lat), 64'd4);
          e = exp12_q.pop_front();
          check("r12_result", obs12(), e);
          stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
          or12 = 1'b0;
          repeat (stall) begin
            @(negedge clk);
            check("r12_hold", obs12(), e);
            check("r12_hold_rdy", 64'(ir12), 64'd0);
          end
          or12 = 1'b1; v12 = 1'b0;
          @(negedge clk);
          or12 = 1'b0;
          if (lat >= 64) break;
        end
      end
    join

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chunked_adder.md
CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter CHUNK, default 4: bits summed per cycle by one carry-lookahead slice.
REQ-003 WIDTH SHALL be a multiple of CHUNK and CHUNK SHALL be >= 1; any other combination SHALL fail elaboration.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  operation request.
REQ-007 in_ready  out  1  block can accept a request.
REQ-008 a  in  WIDTH  first operand.
REQ-009 b  in  WIDTH  second operand.
REQ-010 sub  in  1  0 = add, 1 = subtract.
REQ-011 carry_in  in  1  carry (add) or borrow (sub) input.
REQ-012 out_valid  out  1  result available.
REQ-013 out_ready  in  1  consumer takes the result.
REQ-014 sum  out  WIDTH  result.
REQ-015 carry_out  out  1  carry out of bit WIDTH-1.
REQ-016 overflow  out  1  signed (two's-complement) overflow.
REQ-017 zero  out  1  sum == 0.

Function
REQ-018 FSM states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-019 IDLE, in_valid=1: capture a, b, sub, carry_in; chunk index = 0; go to BUSY. IDLE, in_valid=0: stay.
REQ-020 Effective operand: b_eff = sub ? ~b : b; initial carry c0 = sub ? ~carry_in : carry_in, giving a+b+carry_in (add) or a-b-carry_in (sub), modulo 2^WIDTH.
REQ-021 BUSY cycle k (k = 0 .. WIDTH/CHUNK-1) SHALL compute bits [k*CHUNK +: CHUNK] from propagate (a^b_eff), generate (a&b_eff) and the registered carry from cycle k-1 (c0 for k=0), and register the chunk sum and chunk carry.
REQ-022 Chunks SHALL be processed strictly LSB first; the carry register SHALL carry between chunks only, never wrap from the top chunk to chunk 0.
REQ-023 After the cycle with k = WIDTH/CHUNK-1, the FSM SHALL enter DONE; out_valid rises exactly WIDTH/CHUNK cycles after the accepting edge.
REQ-024 WIDTH == CHUNK SHALL give exactly one BUSY cycle.
REQ-025 carry_out = raw carry from bit WIDTH-1: for sub, 1 means no borrow.
REQ-026 overflow = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]).
REQ-027 zero = (sum == 0), independent of carry_out.
REQ-028 In DONE, sum, carry_out, overflow and zero SHALL hold stable while out_ready=0, for any number of cycles.
REQ-029 DONE with out_ready=1: result is consumed; next state IDLE. A new request SHALL NOT be accepted in the same cycle; the minimum request-to-request spacing is WIDTH/CHUNK+2 cycles.
REQ-030 Input changes to a, b, sub, carry_in or in_valid while in BUSY or DONE SHALL NOT affect the operation in progress.
REQ-031 out_ready SHALL be ignored outside DONE.

Reset
REQ-032 reset=1 at a clock edge SHALL force IDLE and clear sum, carry_out, overflow, zero, out_valid, the chunk index and the carry register to 0 on that edge; in_ready SHALL be 1 on the following cycle.
REQ-033 Reset during BUSY or DONE SHALL abort the operation with no out_valid pulse; reset has priority over in_valid and out_ready on the same edge.

Verification (WIDTH=8, CHUNK=4 unless stated otherwise)
REQ-034 Add with wrap: a=0xFF, b=0x01, sub=0, carry_in=0 -> after 2 cycles: sum=0x00, carry_out=1, zero=1, overflow=0.
REQ-035 Subtract with signed overflow: a=0x80, b=0x01, sub=1, carry_in=0 -> sum=0x7F, carry_out=1, overflow=1, zero=0.
REQ-036 Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> outputs are stable and in_ready=0 throughout; out_ready=1 -> in_ready=1 on the next cycle.
REQ-037 Reset mid-operation: assert reset on the first BUSY cycle -> out_valid never rises, all outputs are 0 and in_ready=1 on the next cycle.
REQ-038 Randomised operation with WIDTH=32, CHUNK=4 and WIDTH=12, CHUNK=3: at least 10k operations with random a, b, sub, carry_in and out_ready stalls -> every result matches a golden model of {carry_out, sum} = a + b_eff + c0, plus the overflow and zero rules above.
